booth2_pp_gen: RTL
==================

Name: booth2_pp_gen

Overview:
Radix-4 (Booth2) partial-product generator for the 16x16 signed multiplier. It accepts a multiplicand/multiplier pair over a valid/ready handshake. It Booth-encodes the multiplier into 8 digits and produces the eight 17-bit partial products PP1..PP8 in the format the partial-product compressor consumes: unshifted, two's complement, PP1 from the lowest multiplier group. It is pipelined (1 or 2 register stages) with full-throughput backpressure and sits directly upstream of the compressor.

Parameters:
ENCODE_REG, 1, 1 = register Booth digits and multiplicand before PP selection (latency 2); 0 = single output register stage (latency 1)
A_W, 16, operand width; only 16 is supported; PP width is A_W+1 = 17

Ports:
sys_clk  input  1  clock, all state updates on rising edge
sys_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operand pair this cycle
mcand  input  16  multiplicand A, signed
mplier  input  16  multiplier B, signed
out_valid  output  1  PP1..PP8 valid
out_ready  input  1  downstream accepts PPs this cycle
PP1..PP8  output  17 each  partial products; PPk corresponds to Booth group k-1
pp_ovf  output  1  the PP set contains an unrepresentable -2*(-32768) term

Behaviour:
- Reset (async, sys_rst_n=0): all stage valid flags = 0, out_valid = 0, PP1..PP8 = 17'h0, pp_ovf = 0, in_ready = 1. Data registers clear to 0. Reset mid-transfer discards all in-flight data, with no output pulse after release.
- Transfer rule: a transfer occurs on a cycle where valid && ready. Inputs are sampled only on in_valid && in_ready.
- Booth group i (i = 0..7) = {B[2i+1], B[2i], B[2i-1]}, where B[-1] = 0.
- Digit mapping: 000 and 111 -> 0; 001 and 010 -> +1; 011 -> +2; 100 -> -2; 101 and 110 -> -1.
- Encoded per group as {neg, one, two}. Digit 0 must give neg = 0.
- PP(i+1) = low 17 bits of d_i * sext17(A). Digit 0 gives exactly 17'h00000. The value for -1 is ~sext(A)+1 computed inside the block; no separate negation bit is exported.
- pp_ovf = 1 iff any digit is -2 and A == 16'h8000. In that case the PP still equals the low 17 bits (17'h10000), and pp_ovf travels with the data.
- Pipeline with ENCODE_REG=1:
  - Stage 1 holds {A, 8 digits, s1_valid}. Stage 2 holds {PP1..PP8, pp_ovf, out_valid}.
  - Stage 2 loads when !out_valid || out_ready.
  - Stage 1 loads when !s1_valid || stage 2 loads.
  - in_ready = !s1_valid || stage 2 loads (combinational from out_ready).
  - Latency: input accepted at edge n; out_valid asserts after edge n+1.
- Pipeline with ENCODE_REG=0: one register stage; in_ready = !out_valid || out_ready; latency 1.
- Throughput: one pair per cycle while out_ready = 1.
- Stall: outputs and pp_ovf hold stable while out_valid && !out_ready. No drop, duplication or reordering.
- Simultaneous accept on input and output in the same cycle is allowed at every stage, with no bubble.

Decomposition:
- Package booth2_pkg holds:
  - width constants: A_W = 16, PP_W = 17, N_PP = 8
  - digit encoding localparams for {neg, one, two}: ZERO, POS1, POS2, NEG1, NEG2
  - the group-to-digit mapping function
- Sub-module booth2_enc_sel: one group's 3-bit encoder plus 17-bit PP selector, with a per-group ovf term. It is instantiated 8 times by generate; the generator splits at the encoder/selector boundary when ENCODE_REG=1.

Test Plan:
- Reset: assert sys_rst_n=0 mid-stream with 2 items in flight, then release -> out_valid=0, PP1..PP8=0, pp_ovf=0, in_ready=1; no stale output ever appears.
- A=16'h0003, B=16'h0001 -> PP1=17'h00003, PP2..PP8=0, pp_ovf=0; out_valid 2 cycles after accept (1 cycle with ENCODE_REG=0).
- A=16'h0005, B=16'hFFFF -> PP1=17'h1FFFB (digit -1), PP2..PP8=0 (groups 111), pp_ovf=0.
- A=16'h7FFF, B=16'h0002 -> PP1=17'h10002 (digit -2); A=16'h7FFF, B=16'h0004 -> PP1=0, PP2=17'h07FFF.
- A=16'h8000, B=16'h0002 -> PP1=17'h10000, pp_ovf=1; A=16'h8000, B=16'h0001 -> PP1=17'h18000, pp_ovf=0.
- Backpressure: stream 10 random pairs with out_ready toggling pseudo-randomly and held 0 for 3 cycles. Required: exactly 2 accepted during the stall (ENCODE_REG=1), then in_ready=0; outputs stable while stalled; in-order, lossless output. Each PP set matches the reference model, and the compressor-summed product equals A*B whenever pp_ovf=0.

Source files
------------

// File: rtl/booth2_pkg.sv
// Shared widths, Booth digit encoding and the group-to-digit mapping for the radix-4 PP generator.
// Latency: none (package).
// Backpressure: none (package).
package booth2_pkg;

  localparam int A_W  = 16;
  localparam int PP_W = A_W + 1;
  localparam int N_PP = 8;

  // Digit encoding {neg, one, two}; zero keeps neg low so the selector yields exactly 0.
  localparam logic [2:0] ZERO = 3'b000;
  localparam logic [2:0] POS1 = 3'b010;
  localparam logic [2:0] POS2 = 3'b001;
  localparam logic [2:0] NEG1 = 3'b110;
  localparam logic [2:0] NEG2 = 3'b101;

  // Stage-1 payload: multiplicand plus the eight encoded digits.
  typedef struct packed {
    logic [A_W-1:0]       a;
    logic [N_PP-1:0][2:0] dig;
  } enc_t;

  // Map a 3-bit group {b[2i+1], b[2i], b[2i-1]} to its encoded digit.
  function automatic logic [2:0] booth_digit(input logic [2:0] grp);
    logic [2:0] d;
    case (grp)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth2_enc_sel.sv
// One Booth group: 3-bit encoder plus 17-bit partial-product selector with the -2*(-32768) flag.
// Latency: purely combinational; encoder and selector are separate so the parent can register between them.
// Backpressure: none (combinational slice).
module booth2_enc_sel
  import booth2_pkg::*;
(
  input  logic [2:0]      grp,
  output logic [2:0]      enc_dig,
  input  logic [2:0]      sel_dig,
  input  logic [A_W-1:0]  sel_a,
  output logic [PP_W-1:0] pp,
  output logic            ovf
);

  logic [PP_W-1:0] a_ext;
  logic [PP_W-1:0] mag;

  assign enc_dig = booth_digit(grp);
  assign a_ext   = {sel_a[A_W-1], sel_a};

  // Pick 0, A or 2A, then two's-complement it for negative digits (low 17 bits kept).
  always_comb begin
    mag = '0;
    if (sel_dig[0])      mag = {a_ext[PP_W-2:0], 1'b0};
    else if (sel_dig[1]) mag = a_ext;
    pp = sel_dig[2] ? (~mag + 1'b1) : mag;
  end

  // -2 * (-32768) = +65536 does not fit in 17 signed bits.
  assign ovf = sel_dig[2] && sel_dig[0] && (sel_a == {1'b1, {(A_W-1){1'b0}}});

endmodule

// File: rtl/booth2_pp_gen.sv
// Radix-4 Booth partial-product generator: 16x16 signed operands in, eight unshifted 17-bit PPs out.
// Latency: 2 cycles with ENCODE_REG=1 (digits registered), 1 cycle with ENCODE_REG=0.
// Backpressure: valid/ready, full throughput; every stage loads when empty or when the next stage drains.
module booth2_pp_gen #(
  parameter int ENCODE_REG = 1,
  parameter int A_W        = 16   // only 16 is supported
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] mcand,
  input  logic [A_W-1:0] mplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W:0]   PP1,
  output logic [A_W:0]   PP2,
  output logic [A_W:0]   PP3,
  output logic [A_W:0]   PP4,
  output logic [A_W:0]   PP5,
  output logic [A_W:0]   PP6,
  output logic [A_W:0]   PP7,
  output logic [A_W:0]   PP8,
  output logic           pp_ovf
);

  import booth2_pkg::*;

  logic [A_W:0]              b_ext;
  logic [N_PP-1:0][2:0]      enc_dig;
  enc_t                      sel_src;
  logic                      src_vld;
  logic                      s2_load;
  logic [N_PP-1:0][PP_W-1:0] pp_nxt;
  logic [N_PP-1:0][PP_W-1:0] pp_q;
  logic [N_PP-1:0]           ovf_nxt;
  logic                      ovf_q;
  logic                      out_vld_q;

  // B[-1] = 0 appended below the LSB so group i is simply b_ext[2i+2:2i].
  assign b_ext   = {mplier, 1'b0};
  assign s2_load = !out_vld_q || out_ready;

  for (genvar gi = 0; gi < N_PP; gi++) begin : g_grp
    booth2_enc_sel u_enc_sel (
      .grp     (b_ext[2*gi +: 3]),
      .enc_dig (enc_dig[gi]),
      .sel_dig (sel_src.dig[gi]),
      .sel_a   (sel_src.a),
      .pp      (pp_nxt[gi]),
      .ovf     (ovf_nxt[gi])
    );
  end

  if (ENCODE_REG != 0) begin : g_enc_reg
    enc_t s1_q;
    logic s1_vld;
    logic s1_load;

    assign s1_load  = !s1_vld || s2_load;
    assign in_ready = s1_load;
    assign sel_src  = s1_q;
    assign src_vld  = s1_vld;

    // Stage 1: capture multiplicand and encoded digits whenever the slot is free or draining.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        s1_vld <= 1'b0;
        s1_q   <= '0;
      end else if (s1_load) begin
        s1_vld <= in_valid;
        if (in_valid) s1_q <= {mcand, enc_dig};
      end
    end
  end else begin : g_no_enc_reg
    assign in_ready = s2_load;
    assign sel_src  = {mcand, enc_dig};
    assign src_vld  = in_valid;
  end

  // Output stage: register the selected PP set and its overflow flag; hold while stalled.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_vld_q <= 1'b0;
      pp_q      <= '0;
      ovf_q     <= 1'b0;
    end else if (s2_load) begin
      out_vld_q <= src_vld;
      if (src_vld) begin
        pp_q  <= pp_nxt;
        ovf_q <= |ovf_nxt;
      end
    end
  end

  assign out_valid = out_vld_q;
  assign pp_ovf    = ovf_q;
  assign PP1 = pp_q[0];
  assign PP2 = pp_q[1];
  assign PP3 = pp_q[2];
  assign PP4 = pp_q[3];
  assign PP5 = pp_q[4];
  assign PP6 = pp_q[5];
  assign PP7 = pp_q[6];
  assign PP8 = pp_q[7];

endmodule
